// File: rtl/frame_bram_packer_if.sv
// rtl/frame_bram_packer_if.sv - pixel stream and bank write bus of frame_bram_packer
//
// Signals:
//   pix_data/pix_valid/pix_sof/pix_ready : grayscale pixel stream (valid/ready handshake)
//   bram_wr_en/bram_wr_addr/bram_wr_data : one-hot bank write port of the correlator BRAMs
// Modports:
//   master : pixel source / BRAM sink side
//   slave  : the packer itself
interface frame_bram_packer_if #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int BRAM_ADDR_WIDTH = 9
);
  logic [PIXEL_WIDTH-1:0]     pix_data;
  logic                       pix_valid;
  logic                       pix_sof;
  logic                       pix_ready;
  logic [15:0]                bram_wr_en;
  logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr;
  logic [127:0]               bram_wr_data;

  modport master (
    output pix_data, pix_valid, pix_sof,
    input  pix_ready,
    input  bram_wr_en, bram_wr_addr, bram_wr_data
  );

  modport slave (
    input  pix_data, pix_valid, pix_sof,
    output pix_ready,
    output bram_wr_en, bram_wr_addr, bram_wr_data
  );
endinterface

// File: rtl/frame_bram_packer.sv
// rtl/frame_bram_packer.sv - binarizes pixels, packs 128 per word into 16 row-interleaved banks, rotates three frame buffers
//
// Ports:
//   Bus2IP_Clk              : clock, rising edge
//   Bus2IP_Resetn           : asynchronous reset, active low
//   enable                  : software enable; low in PACK abandons the frame
//   threshold               : pixel bit = pix_data > threshold
//   corr_busy               : correlator mid-pass; holds off buffer rotation
//   bus (slave)             : pixel stream in, bank write port out
//   curr_frame_bram_offset  : base of newest complete frame
//   prev_frame_bram_offset  : base of previous complete frame
//   frame_done              : one-cycle pulse on rotation
//   pair_valid              : two frames completed since reset
//   sync_err                : sticky, set on a start-of-frame inside a frame
module frame_bram_packer #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int BRAM_ADDR_WIDTH = 9
) (
  input  logic                       Bus2IP_Clk,
  input  logic                       Bus2IP_Resetn,
  input  logic                       enable,
  input  logic [PIXEL_WIDTH-1:0]     threshold,
  input  logic                       corr_busy,
  frame_bram_packer_if.slave         bus,
  output logic [BRAM_ADDR_WIDTH-1:0] curr_frame_bram_offset,
  output logic [BRAM_ADDR_WIDTH-1:0] prev_frame_bram_offset,
  output logic                       frame_done,
  output logic                       pair_valid,
  output logic                       sync_err
);
  localparam int AW  = BRAM_ADDR_WIDTH;
  localparam int WPR = FRAME_WIDTH / 128;
  localparam int B   = (FRAME_HEIGHT / 16) * WPR;
  localparam int CW  = $clog2(FRAME_WIDTH);
  localparam int RW  = $clog2(FRAME_HEIGHT);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_PACK      = 2'd1;
  localparam logic [1:0] S_FRAME_END = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [127:0]  r_pack;
  logic [1:0]    r_done_cnt;
  logic [AW-1:0] r_wr_off;
  logic [AW-1:0] r_curr_off;
  logic [AW-1:0] r_prev_off;
  logic [15:0]   r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [127:0]  r_wr_data;
  logic          r_frame_done;
  logic          r_sync_err;

  logic          w_ready;
  logic          w_accept;
  logic          w_bit;
  logic          w_start;
  logic          w_pack;
  logic          w_resync;
  logic          w_take;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [6:0]    w_col_lo;
  logic          w_col_last;
  logic          w_row_last;
  logic [AW-1:0] w_addr;
  logic [127:0]  w_word;

  assign w_ready  = (r_state != S_FRAME_END);
  assign w_accept = bus.pix_valid & w_ready;
  assign w_bit    = (bus.pix_data > threshold);

  // A pixel is packed either as the frame opener in IDLE or as a regular
  // PACK pixel; an out-of-place SOF restarts the frame at the origin.
  assign w_start  = (r_state == S_IDLE) & w_accept & bus.pix_sof & enable;
  assign w_pack   = (r_state == S_PACK) & w_accept & enable;
  assign w_resync = w_pack & bus.pix_sof & ((r_col != '0) | (r_row != '0));
  assign w_take   = w_start | w_pack;

  // Position of the pixel being accepted this cycle.
  assign w_col      = (w_start | w_resync) ? '0 : r_col;
  assign w_row      = (w_start | w_resync) ? '0 : r_row;
  assign w_col_lo   = w_col[6:0];
  assign w_col_last = (w_col == CW'(FRAME_WIDTH - 1));
  assign w_row_last = (w_row == RW'(FRAME_HEIGHT - 1));

  assign w_addr = r_wr_off + AW'(w_row >> 4) * AW'(WPR) + AW'(w_col >> 7);

  // Word as it looks once the current pixel is merged; the 128th pixel
  // goes straight to the write register without an extra pipeline stage.
  always_comb begin
    w_word           = r_pack;
    w_word[w_col_lo] = w_bit;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_pack       <= '0;
      r_done_cnt   <= '0;
      r_wr_off     <= '0;
      r_curr_off   <= AW'(B);
      r_prev_off   <= AW'(2 * B);
      r_wr_en      <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_wr_en      <= '0;
      r_frame_done <= 1'b0;

      if (w_take) begin
        r_pack <= w_word;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
        if (w_col_lo == 7'h7f) begin
          r_wr_en   <= 16'(1) << w_row[3:0];
          r_wr_addr <= w_addr;
          r_wr_data <= w_word;
        end
      end

      if (w_resync) begin
        r_sync_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_PACK;
          end
        end
        S_PACK: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_accept && w_col_last && w_row_last) begin
            r_state <= S_FRAME_END;
          end
        end
        S_FRAME_END: begin
          if (!corr_busy) begin
            r_prev_off   <= r_curr_off;
            r_curr_off   <= r_wr_off;
            r_wr_off     <= r_prev_off;
            r_frame_done <= 1'b1;
            if (r_done_cnt != 2'd3) begin
              r_done_cnt <= r_done_cnt + 2'd1;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_ready          = w_ready;
  assign bus.bram_wr_en         = r_wr_en;
  assign bus.bram_wr_addr       = r_wr_addr;
  assign bus.bram_wr_data       = r_wr_data;
  assign curr_frame_bram_offset = r_curr_off;
  assign prev_frame_bram_offset = r_prev_off;
  assign frame_done             = r_frame_done;
  assign pair_valid             = r_done_cnt[1];
  assign sync_err               = r_sync_err;
endmodule
